// File: rtl/idma_mp_rsp_combiner.sv
// Merges per-backend responses of a split frontend job into one frontend response.
// Job masks are queued in frontend order; the head job collects until every masked backend answered.
module idma_mp_rsp_combiner #(
    parameter int unsigned NumBEs       = 8,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned JobFifoDepth = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          job_valid_i,
    output logic                          job_ready_o,
    input  logic [NumBEs-1:0]             job_mask_i,
    input  logic [NumBEs-1:0]             be_rsp_valid_i,
    output logic [NumBEs-1:0]             be_rsp_ready_o,
    input  logic [NumBEs-1:0]             be_rsp_error_i,
    input  logic [NumBEs*AddrWidth-1:0]   be_rsp_addr_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic                          rsp_error_o,
    output logic [AddrWidth-1:0]          rsp_addr_o,
    output logic                          busy_o
);

    localparam int unsigned PtrW = $clog2(JobFifoDepth);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned IdxW = (NumBEs > 1) ? $clog2(NumBEs) : 1;

    typedef enum logic {COLLECT, RESPOND} state_e;

    state_e                 state_q;
    logic [NumBEs-1:0]      fifo_q [JobFifoDepth];
    logic [PtrW-1:0]        wptr_q, rptr_q;
    logic [CntW-1:0]        cnt_q;
    logic [NumBEs-1:0]      received_q;
    logic                   err_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [IdxW-1:0]        idx_q;
    logic                   rsp_error_q;
    logic [AddrWidth-1:0]   rsp_addr_q;

    logic                   fifo_empty, fifo_full, push, pop, collect, done;
    logic [NumBEs-1:0]      head_mask, hs, hs_err;
    logic                   new_found, take_new, nxt_err;
    logic [IdxW-1:0]        new_idx, nxt_idx;
    logic [AddrWidth-1:0]   new_addr, nxt_addr;

    assign fifo_empty     = (cnt_q == '0);
    assign fifo_full      = (cnt_q == CntW'(JobFifoDepth));
    assign head_mask      = fifo_q[rptr_q];
    assign collect        = (state_q == COLLECT) && !fifo_empty;
    assign be_rsp_ready_o = collect ? (head_mask & ~received_q) : '0;
    assign hs             = be_rsp_valid_i & be_rsp_ready_o;
    assign hs_err         = hs & be_rsp_error_i;
    // An empty mask trivially matches, so zero-mask jobs finish on their first head cycle.
    assign done           = collect && ((received_q | hs) == head_mask);
    assign push           = job_valid_i && !fifo_full;
    assign pop            = done;

    assign job_ready_o = !fifo_full;
    assign rsp_valid_o = (state_q == RESPOND);
    assign rsp_error_o = rsp_error_q;
    assign rsp_addr_o  = rsp_addr_q;
    assign busy_o      = !fifo_empty || (state_q == RESPOND) || (|received_q);

    // Lowest-index erroring backend among this cycle's handshakes.
    always_comb begin
        new_found = 1'b0;
        new_idx   = '0;
        new_addr  = '0;
        for (int b = NumBEs - 1; b >= 0; b--) begin
            if (hs_err[b]) begin
                new_found = 1'b1;
                new_idx   = IdxW'(b);
                new_addr  = be_rsp_addr_i[b*AddrWidth +: AddrWidth];
            end
        end
    end

    // Backends of one job answer in any order, so a later lower index must still win.
    assign take_new = new_found && (!err_q || (new_idx < idx_q));
    assign nxt_err  = err_q | new_found;
    assign nxt_addr = take_new ? new_addr : addr_q;
    assign nxt_idx  = take_new ? new_idx : idx_q;

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wptr_q] <= job_mask_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= COLLECT;
            received_q  <= '0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            idx_q       <= '0;
            rsp_error_q <= 1'b0;
            rsp_addr_q  <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (done) begin
                        state_q     <= RESPOND;
                        rsp_error_q <= nxt_err;
                        rsp_addr_q  <= nxt_addr;
                        received_q  <= '0;
                        err_q       <= 1'b0;
                        addr_q      <= '0;
                        idx_q       <= '0;
                    end else if (collect) begin
                        received_q <= received_q | hs;
                        err_q      <= nxt_err;
                        addr_q     <= nxt_addr;
                        idx_q      <= nxt_idx;
                    end
                end
                RESPOND: begin
                    if (rsp_ready_i) begin
                        state_q     <= COLLECT;
                        rsp_error_q <= 1'b0;
                        rsp_addr_q  <= '0;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_idma_mp_rsp_combiner.sv
// Directed scenarios plus randomized traffic checked against a job-level scoreboard.
module tb_idma_mp_rsp_combiner;

    localparam int NB = 8;
    localparam int AW = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           job_valid, job_ready;
    logic [NB-1:0]  job_mask;
    logic [NB-1:0]  be_valid, be_ready, be_err;
    logic [NB*AW-1:0] be_addr;
    logic           rsp_valid, rsp_ready, rsp_error, busy;
    logic [AW-1:0]  rsp_addr;

    int n_chk = 0;
    int n_fail = 0;

    idma_mp_rsp_combiner #(.NumBEs(NB), .AddrWidth(AW), .JobFifoDepth(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .job_valid_i(job_valid), .job_ready_o(job_ready), .job_mask_i(job_mask),
        .be_rsp_valid_i(be_valid), .be_rsp_ready_o(be_ready),
        .be_rsp_error_i(be_err), .be_rsp_addr_i(be_addr),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_error_o(rsp_error), .rsp_addr_o(rsp_addr), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_jrdy"}, job_ready, 1);
        chk({tag, "_berdy"}, be_ready, 0);
        chk({tag, "_rvld"}, rsp_valid, 0);
        chk({tag, "_rerr"}, rsp_error, 0);
        chk({tag, "_raddr"}, rsp_addr, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // scoreboard state for the random phase
    logic [NB-1:0]  jm [256];
    logic [NB-1:0]  pe [256];
    logic [AW-1:0]  pa [256][NB];
    int             bptr [NB];
    int             njobs = 0;
    int             nresp = 0;
    logic [AW:0]    exp_q [$];

    function automatic int next_job(input int b, input int from);
        int j = from;
        while (j < njobs && !jm[j][b]) j++;
        return j;
    endfunction

    initial begin
        logic [NB-1:0] hs_r;
        logic          stall_prev, prev_err, jacc, drain;
        logic [AW-1:0] prev_addr;
        logic [AW:0]   e;

        rst = 1'b1; job_valid = 0; job_mask = 0; be_valid = 0; be_err = 0;
        be_addr = '0; rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1 chk_idle("rst");
        @(negedge clk) rst = 1'b0;
        tick();

        // single job, mask 05, BE0 at t, BE2 at t+3
        job_valid = 1; job_mask = 8'h05;
        @(negedge clk) chk("t1_jrdy", job_ready, 1);
        tick(); job_valid = 0;
        be_valid[0] = 1;
        @(negedge clk) chk("t1_rdy_t", be_ready, 8'h05);
        tick(); be_valid = 0;
        repeat (2) begin
            @(negedge clk);
            chk("t1_rdy_wait", be_ready, 8'h04);
            chk("t1_novld", rsp_valid, 0);
            tick();
        end
        be_valid[2] = 1;
        @(negedge clk) chk("t1_rdy_t3", be_ready, 8'h04);
        tick(); be_valid = 0;
        @(negedge clk);
        chk("t1_vld", rsp_valid, 1);
        chk("t1_err", rsp_error, 0);
        chk("t1_addr", rsp_addr, 0);
        chk("t1_berdy_resp", be_ready, 0);
        chk("t1_busy", busy, 1);
        rsp_ready = 1;
        tick(); rsp_ready = 0;
        @(negedge clk);
        chk("t1_vld_done", rsp_valid, 0);
        chk("t1_busy_done", busy, 0);

        // all backends at once, BE5 and BE3 erroring
        job_valid = 1; job_mask = 8'hFF;
        tick(); job_valid = 0;
        be_valid = 8'hFF; be_err = 8'b0010_1000;
        for (int b = 0; b < NB; b++) be_addr[b*AW +: AW] = $urandom;
        be_addr[5*AW +: AW] = 32'h100;
        be_addr[3*AW +: AW] = 32'h200;
        @(negedge clk) chk("t2_rdy", be_ready, 8'hFF);
        tick(); be_valid = 0; be_err = 0;
        @(negedge clk);
        chk("t2_vld", rsp_valid, 1);
        chk("t2_err", rsp_error, 1);
        chk("t2_addr", rsp_addr, 32'h200);
        rsp_ready = 1;
        tick(); rsp_ready = 0;

        // ordering: BE1 of job 2 must stall while job 1 is head
        job_valid = 1; job_mask = 8'h01;
        tick(); job_mask = 8'h03;
        tick(); job_valid = 0;
        be_valid[1] = 1; be_err[1] = 1; be_addr[1*AW +: AW] = 32'h33;
        @(negedge clk) chk("t3_stall_a", be_ready, 8'h01);
        tick();
        @(negedge clk) chk("t3_stall_b", be_ready, 8'h01);
        be_valid[0] = 1; be_err[0] = 0;
        tick(); be_valid[0] = 0;
        @(negedge clk);
        chk("t3_r1_vld", rsp_valid, 1);
        chk("t3_r1_err", rsp_error, 0);
        chk("t3_r1_berdy", be_ready, 0);
        rsp_ready = 1;
        tick(); rsp_ready = 0;
        @(negedge clk) chk("t3_j2_rdy", be_ready, 8'h03);
        be_valid[0] = 1;
        tick(); be_valid = 0; be_err = 0;
        @(negedge clk);
        chk("t3_r2_vld", rsp_valid, 1);
        chk("t3_r2_err", rsp_error, 1);
        chk("t3_r2_addr", rsp_addr, 32'h33);
        rsp_ready = 1;
        tick(); rsp_ready = 0;

        // fill the job FIFO, then drain under backpressure
        job_valid = 1; job_mask = 8'h01;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk) chk("t4_jrdy", job_ready, 1);
            tick();
        end
        job_valid = 0;
        @(negedge clk) chk("t4_full", job_ready, 0);
        for (int k = 0; k < 4; k++) begin
            be_valid[0] = 1; be_err[0] = 1; be_addr[0 +: AW] = 32'h10 + k;
            tick(); be_valid = 0;
            @(negedge clk);
            chk("t4_vld", rsp_valid, 1);
            chk("t4_addr", rsp_addr, 32'h10 + k);
            if (k == 0) chk("t4_jrdy_pop", job_ready, 1);
            tick();
            @(negedge clk);
            chk("t4_hold_vld", rsp_valid, 1);
            chk("t4_hold_err", rsp_error, 1);
            chk("t4_hold_addr", rsp_addr, 32'h10 + k);
            chk("t4_hold_berdy", be_ready, 0);
            rsp_ready = 1;
            tick(); rsp_ready = 0;
        end
        be_err = 0;
        @(negedge clk) chk("t4_busy", busy, 0);

        // zero mask
        tick();
        job_valid = 1; job_mask = 8'h00;
        tick(); job_valid = 0;
        @(negedge clk);
        chk("t5_p1_vld", rsp_valid, 0);
        chk("t5_p1_busy", busy, 1);
        tick();
        @(negedge clk);
        chk("t5_p2_vld", rsp_valid, 1);
        chk("t5_p2_err", rsp_error, 0);
        chk("t5_p2_addr", rsp_addr, 0);
        chk("t5_p2_busy", busy, 1);
        rsp_ready = 1;
        tick(); rsp_ready = 0;
        @(negedge clk) chk("t5_busy_done", busy, 0);

        // reset with two jobs queued and a partial receive
        tick();
        job_valid = 1; job_mask = 8'h03;
        tick(); job_mask = 8'h07;
        tick(); job_valid = 0;
        be_valid[0] = 1;
        tick(); be_valid = 0;
        @(negedge clk) chk("t6_busy_pre", busy, 1);
        rst = 1;
        #1 chk_idle("t6_rst");
        tick();
        @(negedge clk) rst = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            chk("t6_post_vld", rsp_valid, 0);
            chk("t6_post_busy", busy, 0);
        end
        tick();

        // randomized traffic against the job scoreboard
        for (int b = 0; b < NB; b++) bptr[b] = 0;
        hs_r = '0; stall_prev = 0; prev_err = 0; prev_addr = '0; jacc = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            drain = (cyc >= 1500);
            if (jacc || !job_valid) begin
                job_valid = !drain && (njobs < 250) && ($urandom % 3 == 0);
                job_mask  = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom);
            end
            rsp_ready = drain ? 1'b1 : ($urandom % 3 != 0);
            for (int b = 0; b < NB; b++) begin
                if (hs_r[b]) be_valid[b] = 0;
                if (!be_valid[b]) begin
                    bptr[b] = next_job(b, bptr[b]);
                    if (bptr[b] < njobs && $urandom % 2 == 1) begin
                        be_valid[b] = 1;
                        be_err[b]   = pe[bptr[b]][b];
                        be_addr[b*AW +: AW] = pa[bptr[b]][b];
                    end
                end
            end

            @(negedge clk);
            hs_r = be_valid & be_ready;
            for (int b = 0; b < NB; b++) if (hs_r[b]) bptr[b]++;
            if (stall_prev) begin
                chk("rnd_hold_vld", rsp_valid, 1);
                chk("rnd_hold_err", rsp_error, prev_err);
                chk("rnd_hold_addr", rsp_addr, prev_addr);
            end
            if (rsp_valid) chk("rnd_resp_berdy", be_ready, 0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_err", rsp_error, e[AW]);
                    chk("rnd_addr", rsp_addr, e[AW-1:0]);
                end
                nresp++;
            end
            stall_prev = rsp_valid && !rsp_ready;
            prev_err   = rsp_error;
            prev_addr  = rsp_addr;
            jacc = job_valid && job_ready;
            if (jacc) begin
                logic [NB-1:0] em;
                jm[njobs] = job_mask;
                pe[njobs] = 8'($urandom) & 8'($urandom);
                for (int b = 0; b < NB; b++) pa[njobs][b] = $urandom;
                em = job_mask & pe[njobs];
                e = '0;
                for (int b = NB - 1; b >= 0; b--)
                    if (em[b]) e = {1'b1, pa[njobs][b]};
                exp_q.push_back(e);
                njobs++;
            end
            tick();
        end
        job_valid = 0; be_valid = 0;
        @(negedge clk);
        chk("rnd_count", nresp, njobs);
        chk("rnd_exp_empty", exp_q.size(), 0);
        chk("rnd_busy_end", busy, 0);
        chk("rnd_some_jobs", (njobs > 50), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
